descriptor_memory_arbiter: RTL
==============================

// Module: descriptor_memory_arbiter
// PURPOSE
//  Shares the single-port 1024x32 descriptor RAM between two Avalon-MM requesters:
//  m0 = Nios data master, m1 = DMA descriptor-fetch engine.
//  Work-conserving round-robin arbiter. Issues one RAM access per cycle.
//  Returns read data to the granted requester one cycle after issue (RAM read latency 1).
// PARAMETERS
//  ADDR_W  10  word address width; RAM depth = 2**ADDR_W
//  DATA_W  32  data width
//  BE_W    4   byteenable width = DATA_W/8
// PORTS
//  clk              in   1       system clock
//  reset_n          in   1       synchronous, active-low reset
//  mN_address       in   ADDR_W  requester N word address (N = 0,1)
//  mN_byteenable    in   BE_W    requester N byte lanes
//  mN_read          in   1       requester N read request
//  mN_write         in   1       requester N write request
//  mN_writedata     in   DATA_W  requester N write data
//  mN_waitrequest   out  1       high = request not accepted this cycle
//  mN_readdata      out  DATA_W  read data, valid with mN_readdatavalid
//  mN_readdatavalid out  1       one-cycle read-return strobe
//  mN_lock          in   1       hold grant (only with DESC_ARB_LOCK_EN)
//  mem_address      out  ADDR_W  RAM address
//  mem_byteenable   out  BE_W    RAM byte lanes
//  mem_chipselect   out  1       RAM access strobe
//  mem_write        out  1       RAM write strobe
//  mem_writedata    out  DATA_W  RAM write data
//  mem_readdata     in   DATA_W  RAM q, valid one cycle after the read issue
//  mem_clken        out  1       tied 1
// BEHAVIOUR
//  - Request: req_N = mN_read | mN_write. If read & write are both high, treat as write.
//  - Grant is combinational each cycle; waitrequest = req_N & ~gnt_N.
//    Non-requesting master sees waitrequest 0. A master holds its signals while waitrequest is high.
//  - Round-robin: if only one master requests, it wins.
//    If both request, the master not in last_gnt wins.
//    last_gnt register updates on every granted cycle.
//  - Granted access drives mem_* the same cycle (mem_chipselect = |gnt).
//    mem_write = granted write.
//  - Read return: registers rd_pend/rd_owner at issue.
//    Next cycle, mOwner_readdatavalid = 1 and mOwner_readdata = mem_readdata.
//    Other master's readdatavalid = 0.
//    readdata outputs are a mux; hold mem_readdata when not valid.
//  - Throughput: 1 access/cycle. Back-to-back reads from alternating masters need no bubbles.
//    A read issued while the previous return is in flight is legal.
//  - Writes produce no response. Read-after-write to the same address on consecutive cycles
//    returns the new data (single port, write completes first).
//  - Reset (reset_n = 0 at a clk edge):
//    last_gnt = 1 (m0 has priority first), rd_pend = 0, all readdatavalid = 0.
//    A read in flight when reset is sampled is dropped (no readdatavalid).
//    While reset_n = 0: mem_chipselect = 0 and both waitrequest = 1.
// CONFIGURATION
//  DESC_ARB_LOCK_EN defined:
//    - While the current owner holds mN_lock = 1, it keeps the grant and the other master waits.
//      This applies even on idle cycles (owner may pause without losing the lock).
//    - Lock releases the cycle after mN_lock falls.
//    - lock_owner/lock_active registers are cleared by reset.
//  DESC_ARB_LOCK_EN undefined: mN_lock ports exist but are ignored; pure round-robin.
// STRUCTURE
//  - Package desc_arb_pkg:
//    ADDR_W/DATA_W/BE_W defaults; typedef enum {M0, M1} owner_t;
//    typedef struct {addr, be, rd, wr, wdata} av_req_t.
//  - Sub-module desc_arb_rr: 2-way round-robin picker.
//    Inputs: req[1:0], last_gnt, optional lock. Output: one-hot gnt.
//  - Top level: mem_* muxing, read-return pipeline register, waitrequest generation.
// TESTING
//  1 m0 read addr 5 (RAM[5]=0xDEADBEEF), m1 idle ->
//    mem_address=5 cycle 0; m0_readdatavalid=1 with 0xDEADBEEF cycle 1.
//  2 After reset, m0 and m1 read at the same time (addr 1 and 2) ->
//    m0 granted cycle 0 (m1_waitrequest=1); m1 granted cycle 1; returns in cycles 1 and 2.
//  3 Both masters stream 4 reads each ->
//    grants strictly alternate m0,m1,...; 8 readdatavalid pulses in 8 consecutive cycles.
//  4 m1 write addr 7, data 0x11223344, be=4'b0011 over 0xFFFFFFFF; m0 reads addr 7 next cycle ->
//    m0 gets 0xFFFF3344.
//  5 LOCK_EN: m0 holds lock for 3 accesses plus 1 idle cycle while m1 requests ->
//    m1_waitrequest=1 throughout; m1 granted the cycle after lock falls.
//  6 m0 read issued, then reset_n=0 the next edge ->
//    no m0_readdatavalid; after release, m0 wins the first contention.

Source files
------------

// File: rtl/desc_arb_pkg.sv
// Shared types and default widths for the descriptor RAM arbiter.
// Optional grant locking is built when DESC_ARB_LOCK_EN is defined.
package desc_arb_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } av_req_t;

endpackage

// File: rtl/desc_arb_rr.sv
// Two-way round-robin picker with an optional grant hold for the lock owner.
// Lock inputs are driven inactive unless DESC_ARB_LOCK_EN is defined.
module desc_arb_rr
  import desc_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_gnt,
  input  logic       lock_active,
  input  owner_t     lock_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (lock_active) begin
      // Only the lock owner may be granted, even when it is idle.
      if (lock_owner == M0) begin
        gnt = {1'b0, req[0]};
      end else begin
        gnt = {req[1], 1'b0};
      end
    end else if (req == 2'b11) begin
      gnt = (last_gnt == M1) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/descriptor_memory_arbiter.sv
// Shares a single-port descriptor RAM between two Avalon-MM requesters, one access per cycle.
// Define DESC_ARB_LOCK_EN to let the current owner hold the grant with mN_lock.
module descriptor_memory_arbiter #(
  parameter int unsigned ADDR_W = desc_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = desc_arb_pkg::DATA_W,
  parameter int unsigned BE_W   = desc_arb_pkg::BE_W
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m0_lock,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              m1_lock,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              mem_clken
);

  import desc_arb_pkg::*;

  av_req_t    req_0;
  av_req_t    req_1;
  av_req_t    sel;
  logic [1:0] req;
  logic [1:0] gnt_rr;
  logic [1:0] gnt;
  owner_t     gnt_owner;
  owner_t     last_gnt;
  owner_t     rd_owner;
  logic       rd_pend;
  logic       lock_active;
  owner_t     lock_owner;

  // Read and write together is treated as a write.
  always_comb begin
    req_0       = '0;
    req_0.addr  = m0_address;
    req_0.be    = m0_byteenable;
    req_0.rd    = m0_read & ~m0_write;
    req_0.wr    = m0_write;
    req_0.wdata = m0_writedata;
    req_1       = '0;
    req_1.addr  = m1_address;
    req_1.be    = m1_byteenable;
    req_1.rd    = m1_read & ~m1_write;
    req_1.wr    = m1_write;
    req_1.wdata = m1_writedata;
  end

  assign req = {req_1.rd | req_1.wr, req_0.rd | req_0.wr};

  desc_arb_rr u_rr (
    .req         (req),
    .last_gnt    (last_gnt),
    .lock_active (lock_active),
    .lock_owner  (lock_owner),
    .gnt         (gnt_rr)
  );

  assign gnt       = reset_n ? gnt_rr : 2'b00;
  assign gnt_owner = gnt[1] ? M1 : M0;
  assign sel       = gnt[1] ? req_1 : req_0;

  assign mem_address    = sel.addr;
  assign mem_byteenable = sel.be;
  assign mem_writedata  = sel.wdata;
  assign mem_chipselect = |gnt;
  assign mem_write      = (|gnt) & sel.wr;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = ~reset_n | (req[0] & ~gnt[0]);
  assign m1_waitrequest = ~reset_n | (req[1] & ~gnt[1]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gnt <= M1;
      rd_pend  <= 1'b0;
      rd_owner <= M0;
    end else begin
      rd_pend <= (|gnt) & sel.rd;
      if (|gnt) begin
        last_gnt <= gnt_owner;
        rd_owner <= gnt_owner;
      end
    end
  end

  // Return strobes are masked while reset is low so an in-flight read is dropped.
  assign m0_readdatavalid = reset_n & rd_pend & (rd_owner == M0);
  assign m1_readdatavalid = reset_n & rd_pend & (rd_owner == M1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

`ifdef DESC_ARB_LOCK_EN
  logic owner_lock;
  logic gnt_lock;

  assign owner_lock = (lock_owner == M1) ? m1_lock : m0_lock;
  assign gnt_lock   = (gnt_owner == M1) ? m1_lock : m0_lock;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_active <= 1'b0;
      lock_owner  <= M0;
    end else if (lock_active) begin
      if (!owner_lock) begin
        lock_active <= 1'b0;
      end
    end else if ((|gnt) && gnt_lock) begin
      lock_active <= 1'b1;
      lock_owner  <= gnt_owner;
    end
  end
`else
  logic unused_lock;

  assign lock_active = 1'b0;
  assign lock_owner  = M0;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

endmodule
